// File: rtl/can_pkg.sv
// Shared CAN definitions: interframe state encoding and the
// default intermission, suspend and overload limits.
package can_pkg;

  localparam int ITM_LEN_DEF     = 3;
  localparam int SUSPEND_LEN_DEF = 8;
  localparam int OVRLD_MAX_DEF   = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    ITM     = 3'd2,
    WAIT_OE = 3'd3,
    SUSPEND = 3'd4
  } itm_state_e;

endpackage

// File: rtl/itm_checker.sv
// Interframe-space checker: tracks intermission, suspend and idle,
// flags overload conditions and start-of-frame on the sampled bus.
//
// Ports:
//   SP          sample-point clock, state changes on rising edge
//   reset       async active-low reset
//   RX          sampled bus bit, 0 = dominant
//   EOF_DONE    active-low, decoder finished end-of-frame
//   F_ITMSS     active-low, overload/error delimiter finished
//   ERR_PASSIVE node is error-passive
//   WAS_TX      node transmitted the last frame
//   F_OVRLD     active-low one-cycle overload request
//   F_ERR       one-cycle form-error pulse
//   SOF         one-cycle start-of-frame pulse
//   BUS_IDLE    high while in IDLE
//   OVRLD_CNT   consecutive overload count, saturating
module itm_checker
  import can_pkg::*;
#(
  parameter int ITM_LEN     = ITM_LEN_DEF,
  parameter int SUSPEND_LEN = SUSPEND_LEN_DEF,
  parameter int OVRLD_MAX   = OVRLD_MAX_DEF
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       EOF_DONE,
  input  logic       F_ITMSS,
  input  logic       ERR_PASSIVE,
  input  logic       WAS_TX,
  output logic       F_OVRLD,
  output logic       F_ERR,
  output logic       SOF,
  output logic       BUS_IDLE,
  output logic [1:0] OVRLD_CNT
);

  localparam logic [3:0] ITM_LAST =
    4'(ITM_LEN - 1);
  localparam logic [3:0] SUS_LAST =
    4'(SUSPEND_LEN - 1);
  localparam logic [1:0] OC_MAX =
    2'(OVRLD_MAX);

  itm_state_e state_q;
  itm_state_e state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [1:0] oc_q;
  logic [1:0] oc_d;
  logic       sof_q;
  logic       sof_d;
  logic       err_q;
  logic       err_d;
  logic       ovl_n_q;
  logic       ovl_n_d;

  logic itm_last;
  logic sus_last;
  logic oc_full;

  assign itm_last = (cnt_q == ITM_LAST);
  assign sus_last = (cnt_q == SUS_LAST);
  assign oc_full  = (oc_q >= OC_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oc_d    = oc_q;
    sof_d   = 1'b0;
    err_d   = 1'b0;
    ovl_n_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!RX) begin
          sof_d   = 1'b1;
          oc_d    = 2'd0;
          state_d = RECV;
        end
      end

      RECV: begin
        // either completion strobe opens intermission,
        // both together still give one entry
        if (!EOF_DONE || !F_ITMSS) begin
          state_d = ITM;
        end
      end

      ITM: begin
        unique case (1'b1)
          (!RX && !itm_last): begin
            // dominant inside intermission
            if (oc_full) begin
              err_d = 1'b1;
            end else begin
              ovl_n_d = 1'b0;
              oc_d    = oc_q + 2'd1;
            end
            state_d = WAIT_OE;
          end
          (!RX && itm_last): begin
            // dominant on last bit is a new frame
            sof_d   = 1'b1;
            oc_d    = 2'd0;
            state_d = RECV;
          end
          (RX && itm_last): begin
            oc_d = 2'd0;
            if (ERR_PASSIVE && WAS_TX) begin
              state_d = SUSPEND;
            end else begin
              state_d = IDLE;
            end
          end
          default: begin
            cnt_d = cnt_q + 4'd1;
          end
        endcase
      end

      WAIT_OE: begin
        if (!F_ITMSS) begin
          state_d = ITM;
        end
      end

      SUSPEND: begin
        if (!RX) begin
          sof_d   = 1'b1;
          state_d = RECV;
        end else if (sus_last) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      oc_q    <= 2'd0;
      sof_q   <= 1'b0;
      err_q   <= 1'b0;
      ovl_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oc_q    <= oc_d;
      sof_q   <= sof_d;
      err_q   <= err_d;
      ovl_n_q <= ovl_n_d;
    end
  end

  assign F_OVRLD   = ovl_n_q;
  assign F_ERR     = err_q;
  assign SOF       = sof_q;
  assign BUS_IDLE  = (state_q == IDLE);
  assign OVRLD_CNT = oc_q;

endmodule

// File: tb/tb_itm_checker.sv
// Self-checking bench for itm_checker: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_itm_checker;

  localparam int ILEN = 3;
  localparam int SLEN = 8;
  localparam int OMAX = 2;

  logic       sp;
  logic       reset;
  logic       rx;
  logic       eof_done;
  logic       f_itmss;
  logic       err_passive;
  logic       was_tx;
  logic       f_ovrld;
  logic       f_err;
  logic       sof;
  logic       bus_idle;
  logic [1:0] ovrld_cnt;

  int checks;
  int errors;

  itm_checker #(
    .ITM_LEN    (ILEN),
    .SUSPEND_LEN(SLEN),
    .OVRLD_MAX  (OMAX)
  ) dut (
    .SP         (sp),
    .reset      (reset),
    .RX         (rx),
    .EOF_DONE   (eof_done),
    .F_ITMSS    (f_itmss),
    .ERR_PASSIVE(err_passive),
    .WAS_TX     (was_tx),
    .F_OVRLD    (f_ovrld),
    .F_ERR      (f_err),
    .SOF        (sof),
    .BUS_IDLE   (bus_idle),
    .OVRLD_CNT  (ovrld_cnt)
  );

  initial sp = 1'b0;
  always #5 sp = ~sp;

  logic [5:0] obs;
  assign obs = {f_ovrld, f_err, sof, bus_idle, ovrld_cnt};

  function automatic logic [5:0] ev(
    input logic ovl_n, input logic err,
    input logic s, input logic idle,
    input int oc);
    ev = {ovl_n, err, s, idle, 2'(oc)};
  endfunction

  task automatic tick();
    @(posedge sp);
    #1;
  endtask

  task automatic do_reset();
    rx = 1'b1;
    eof_done = 1'b1;
    f_itmss = 1'b1;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    #1;
  endtask

  task automatic to_itm();
    do_reset();
    rx = 1'b0;
    tick();
    rx = 1'b1;
    eof_done = 1'b0;
    tick();
    eof_done = 1'b1;
  endtask

  task automatic test_reset();
    rx = 1'b1;
    eof_done = 1'b1;
    f_itmss = 1'b1;
    err_passive = 1'b0;
    was_tx = 1'b0;
    reset = 1'b0;
    #12;
    checks++;
    if (obs !== ev(1, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL reset_state got %b want %b",
               obs, ev(1, 0, 0, 1, 0));
    end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_sof();
    do_reset();
    rx = 1'b0;
    tick();
    checks++;
    if (obs !== ev(1, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL sof_pulse got %b want %b",
               obs, ev(1, 0, 1, 0, 0));
    end
    rx = 1'b1;
    tick();
    checks++;
    if (obs !== ev(1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL sof_one_cycle got %b want %b",
               obs, ev(1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_itm_idle();
    do_reset();
    rx = 1'b0;
    tick();
    rx = 1'b1;
    eof_done = 1'b0;
    f_itmss = 1'b0;
    tick();
    eof_done = 1'b1;
    f_itmss = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== ev(1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL itm_bit2_busy got %b want %b",
               obs, ev(1, 0, 0, 0, 0));
    end
    tick();
    checks++;
    if (obs !== ev(1, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL itm_to_idle got %b want %b",
               obs, ev(1, 0, 0, 1, 0));
    end
  endtask

  task automatic test_overload();
    to_itm();
    rx = 1'b1;
    tick();
    rx = 1'b0;
    tick();
    checks++;
    if (obs !== ev(0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL ovl_first got %b want %b",
               obs, ev(0, 0, 0, 0, 1));
    end
    tick();
    checks++;
    if (obs !== ev(1, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL ovl_wait_rx_ignored got %b want %b",
               obs, ev(1, 0, 0, 0, 1));
    end
    rx = 1'b1;
    f_itmss = 1'b0;
    tick();
    f_itmss = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (obs !== ev(1, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL ovl_back_to_itm got %b want %b",
               obs, ev(1, 0, 0, 1, 0));
    end
  endtask

  task automatic test_overload_sat();
    to_itm();
    rx = 1'b0;
    tick();
    f_itmss = 1'b0;
    rx = 1'b1;
    tick();
    f_itmss = 1'b1;
    rx = 1'b0;
    tick();
    checks++;
    if (obs !== ev(0, 0, 0, 0, 2)) begin
      errors++;
      $display("FAIL ovl_second got %b want %b",
               obs, ev(0, 0, 0, 0, 2));
    end
    f_itmss = 1'b0;
    rx = 1'b1;
    tick();
    f_itmss = 1'b1;
    rx = 1'b0;
    tick();
    checks++;
    if (obs !== ev(1, 1, 0, 0, 2)) begin
      errors++;
      $display("FAIL ovl_saturate_err got %b want %b",
               obs, ev(1, 1, 0, 0, 2));
    end
    rx = 1'b1;
    tick();
    checks++;
    if (obs !== ev(1, 0, 0, 0, 2)) begin
      errors++;
      $display("FAIL err_one_cycle got %b want %b",
               obs, ev(1, 0, 0, 0, 2));
    end
    f_itmss = 1'b0;
    tick();
    f_itmss = 1'b1;
    tick();
    tick();
    rx = 1'b0;
    tick();
    checks++;
    if (obs !== ev(1, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL itm_last_bit_sof got %b want %b",
               obs, ev(1, 0, 1, 0, 0));
    end
    rx = 1'b1;
  endtask

  task automatic test_suspend();
    err_passive = 1'b1;
    was_tx = 1'b1;
    to_itm();
    rx = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs !== ev(1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL suspend_entry got %b want %b",
               obs, ev(1, 0, 0, 0, 0));
    end
    repeat (4) tick();
    rx = 1'b0;
    tick();
    checks++;
    if (obs !== ev(1, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL suspend_sof got %b want %b",
               obs, ev(1, 0, 1, 0, 0));
    end
    rx = 1'b1;
    eof_done = 1'b0;
    tick();
    eof_done = 1'b1;
    repeat (3) tick();
    repeat (SLEN - 1) tick();
    checks++;
    if (obs !== ev(1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL suspend_bit7_busy got %b want %b",
               obs, ev(1, 0, 0, 0, 0));
    end
    tick();
    checks++;
    if (obs !== ev(1, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL suspend_to_idle got %b want %b",
               obs, ev(1, 0, 0, 1, 0));
    end
    err_passive = 1'b0;
    was_tx = 1'b0;
  endtask

  task automatic test_reset_mid();
    to_itm();
    rx = 1'b0;
    tick();
    f_itmss = 1'b0;
    rx = 1'b1;
    tick();
    f_itmss = 1'b1;
    rx = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== ev(1, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL reset_mid_pulse got %b want %b",
               obs, ev(1, 0, 0, 1, 0));
    end
    reset = 1'b1;
    #1;
    rx = 1'b0;
    tick();
    checks++;
    if (obs !== ev(1, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL first_edge_idle got %b want %b",
               obs, ev(1, 0, 1, 0, 0));
    end
    rx = 1'b1;
  endtask

  // behavioural reference
  string m_mode;
  int    m_bits;
  int    m_oc;
  logic  m_sof;
  logic  m_err;
  logic  m_ovl_n;

  task automatic m_go(input string nxt);
    if (nxt != m_mode) m_bits = 0;
    m_mode = nxt;
  endtask

  task automatic m_reset();
    m_mode = "IDLE";
    m_bits = 0;
    m_oc = 0;
    m_sof = 0;
    m_err = 0;
    m_ovl_n = 1;
  endtask

  task automatic m_step(input logic r, input logic e,
                        input logic f, input logic p,
                        input logic w);
    m_sof = 0;
    m_err = 0;
    m_ovl_n = 1;
    if (m_mode == "IDLE") begin
      if (!r) begin
        m_sof = 1;
        m_oc = 0;
        m_go("RECV");
      end
    end else if (m_mode == "RECV") begin
      if (!e || !f) m_go("ITM");
    end else if (m_mode == "ITM") begin
      if (!r && m_bits < ILEN - 1) begin
        if (m_oc < OMAX) begin
          m_ovl_n = 0;
          m_oc++;
        end else begin
          m_err = 1;
        end
        m_go("WAIT");
      end else if (!r) begin
        m_sof = 1;
        m_oc = 0;
        m_go("RECV");
      end else if (m_bits == ILEN - 1) begin
        m_oc = 0;
        m_go((p && w) ? "SUSP" : "IDLE");
      end else begin
        m_bits++;
      end
    end else if (m_mode == "WAIT") begin
      if (!f) m_go("ITM");
    end else begin
      if (!r) begin
        m_sof = 1;
        m_go("RECV");
      end else if (m_bits == SLEN - 1) begin
        m_go("IDLE");
      end else begin
        m_bits++;
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] want;
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      rx = ($urandom_range(0, 3) != 0);
      eof_done = ($urandom_range(0, 4) != 0);
      f_itmss = ($urandom_range(0, 3) != 0);
      err_passive = $urandom_range(0, 1) == 1;
      was_tx = $urandom_range(0, 1) == 1;
      m_step(rx, eof_done, f_itmss,
             err_passive, was_tx);
      tick();
      want = ev(m_ovl_n, m_err, m_sof,
                m_mode == "IDLE", m_oc);
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL random_cycle%0d got %b want %b",
                 i, obs, want);
      end
      if ($urandom_range(0, 249) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        checks++;
        if (obs !== ev(1, 0, 0, 1, 0)) begin
          errors++;
          $display("FAIL random_reset got %b want %b",
                   obs, ev(1, 0, 0, 1, 0));
        end
        reset = 1'b1;
        #1;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sof();
    test_itm_idle();
    test_overload();
    test_overload_sat();
    test_suspend();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
